// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, two read ports and the clear/busy pair.
//   master : the decoder/datapath side driving addresses, write data and clear
//   slave  : the register file returning registered read data and busy
// AW must equal the register file's address width, $clog2(DEPTH).
interface regfile_mp_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 3
);
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    writenum;
    logic             write;
    logic [AW-1:0]    readnum_a;
    logic [AW-1:0]    readnum_b;
    logic [WIDTH-1:0] data_out_a;
    logic [WIDTH-1:0] data_out_b;
    logic             clear;
    logic             busy;

    modport master (
        output data_in, writenum, write, readnum_a, readnum_b, clear,
        input  data_out_a, data_out_b, busy
    );

    modport slave (
        input  data_in, writenum, write, readnum_a, readnum_b, clear,
        output data_out_a, data_out_b, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Register file with one write port and two registered read ports (A/B).
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; zeroes array, read data, clear engine
//   bus   : regfile_mp_if slave modport
//     data_in/writenum/write     write port (dropped while busy or out of range)
//     readnum_a/b -> data_out_a/b  latency-1 reads, out-of-range reads return 0
//     clear -> busy              sequenced zeroing sweep, one entry per cycle
// BYPASS=1 forwards an accepted same-edge write to a matching read port.
module regfile_mp #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned BYPASS = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH itself is representable for the range checks.
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    localparam logic ST_IDLE     = 1'b0;
    localparam logic ST_CLEARING = 1'b1;

    logic             state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    logic             wr_accept;
    logic [WIDTH-1:0] rd_a_data;
    logic [WIDTH-1:0] rd_b_data;

    // Writes are only taken while idle; the sweep owns the array otherwise.
    always_comb begin
        wr_accept = bus.write && (state == ST_IDLE) && ({1'b0, bus.writenum} < DEPTH_W);
    end

    // Read mux; sweep zeroing is not forwarded, so the swept entry reads pre-zero.
    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        if ({1'b0, bus.readnum_a} < DEPTH_W) begin
            rd_a_data = regs[bus.readnum_a];
        end
        if ({1'b0, bus.readnum_b} < DEPTH_W) begin
            rd_b_data = regs[bus.readnum_b];
        end
        if (BYPASS != 0 && wr_accept && bus.writenum == bus.readnum_a) begin
            rd_a_data = bus.data_in;
        end
        if (BYPASS != 0 && wr_accept && bus.writenum == bus.readnum_b) begin
            rd_b_data = bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            out_a <= '0;
            out_b <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else begin
            out_a <= rd_a_data;
            out_b <= rd_b_data;
            case (state)
                ST_IDLE: begin
                    // A write on the clear edge lands; the sweep erases it later.
                    if (wr_accept) begin
                        regs[bus.writenum] <= bus.data_in;
                    end
                    if (bus.clear) begin
                        state <= ST_CLEARING;
                        ptr   <= '0;
                    end
                end
                ST_CLEARING: begin
                    // clear is ignored here: no restart mid-sweep.
                    regs[ptr] <= '0;
                    if (ptr == LAST) begin
                        ptr   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.busy       = (state == ST_CLEARING);
    assign bus.data_out_a = out_a;
    assign bus.data_out_b = out_b;
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
    logic clk;
    logic reset;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (16x8, bypass), no-bypass instance, and a 32x5 instance.
    regfile_mp_if #(.WIDTH(16), .AW(3)) bm ();
    regfile_mp_if #(.WIDTH(16), .AW(3)) bn ();
    regfile_mp_if #(.WIDTH(32), .AW(3)) bs ();

    regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_main (.clk(clk), .reset(reset), .bus(bm));
    regfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_nb   (.clk(clk), .reset(reset), .bus(bn));
    regfile_mp #(.WIDTH(32), .DEPTH(5), .BYPASS(1)) u_sm   (.clk(clk), .reset(reset), .bus(bs));

    // Reference model of the main instance plus scoreboard queues.
    logic [15:0] mm [8];
    logic        mbusy;
    int          mptr;
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic        qbusy [$];
    logic [15:0] qn [$];
    logic [31:0] qs_a [$];
    logic [31:0] qs_b [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mm[i] = '0;
        mbusy = 1'b0;
        mptr  = 0;
        qa.delete();
        qb.delete();
        qbusy.delete();
    endtask

    // Drive one cycle on the main instance; push expected outputs for that edge.
    task automatic drive_main(input logic w, input logic [2:0] wn, input logic [15:0] d,
                              input logic [2:0] ra, input logic [2:0] rb, input logic clr);
        logic [15:0] ea;
        logic [15:0] eb;
        logic        acc;
        bm.write     = w;
        bm.writenum  = wn;
        bm.data_in   = d;
        bm.readnum_a = ra;
        bm.readnum_b = rb;
        bm.clear     = clr;
        acc = w && !mbusy;
        ea  = (acc && wn == ra) ? d : mm[ra];
        eb  = (acc && wn == rb) ? d : mm[rb];
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk);
        if (mbusy) begin
            mm[mptr] = '0;
            if (mptr == 7) begin
                mbusy = 1'b0;
                mptr  = 0;
            end else begin
                mptr++;
            end
        end else begin
            if (acc) mm[wn] = d;
            if (clr) begin
                mbusy = 1'b1;
                mptr  = 0;
            end
        end
        qbusy.push_back(mbusy);
        #1;
        bm.write = 1'b0;
        bm.clear = 1'b0;
    endtask

    task automatic idle_all();
        bm.write = 0; bm.writenum = 0; bm.data_in = 0; bm.readnum_a = 0; bm.readnum_b = 0;
        bm.clear = 0;
        bn.write = 0; bn.writenum = 0; bn.data_in = 0; bn.readnum_a = 0; bn.readnum_b = 0;
        bn.clear = 0;
        bs.write = 0; bs.writenum = 0; bs.data_in = 0; bs.readnum_a = 0; bs.readnum_b = 0;
        bs.clear = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_all();
        model_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bm.busy !== 1'b0 || bn.busy !== 1'b0 || bs.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b%b%b exp 000", bm.busy, bn.busy, bs.busy);
        end
        n_cmp++;
        if (bm.data_out_a !== 16'h0 || bm.data_out_b !== 16'h0) begin
            n_err++;
            $display("FAIL reset_main_out: got %h/%h exp 0/0", bm.data_out_a, bm.data_out_b);
        end
        n_cmp++;
        if (bs.data_out_a !== 32'h0 || bs.data_out_b !== 32'h0) begin
            n_err++;
            $display("FAIL reset_small_out: got %h/%h exp 0/0", bs.data_out_a, bs.data_out_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_write_bypass();
        logic [15:0] ea;
        drive_main(1'b1, 3'd3, 16'd42, 3'd3, 3'd0, 1'b0);
        ea = qa.pop_front(); void'(qb.pop_front()); void'(qbusy.pop_front());
        n_cmp++;
        if (bm.data_out_a !== ea) begin
            n_err++;
            $display("FAIL bypass_same_edge: got %h exp %h", bm.data_out_a, ea);
        end
        drive_main(1'b0, 3'd0, 16'd0, 3'd3, 3'd0, 1'b0);
        ea = qa.pop_front(); void'(qb.pop_front()); void'(qbusy.pop_front());
        n_cmp++;
        if (bm.data_out_a !== ea) begin
            n_err++;
            $display("FAIL bypass_hold: got %h exp %h", bm.data_out_a, ea);
        end
    endtask

    task automatic test_dual_read();
        logic [15:0] ea;
        logic [15:0] eb;
        drive_main(1'b1, 3'd1, 16'h1111, 3'd0, 3'd0, 1'b0);
        drive_main(1'b1, 3'd6, 16'h6666, 3'd0, 3'd0, 1'b0);
        qa.delete(); qb.delete(); qbusy.delete();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive_main(1'b0, 3'd0, 16'd0, 3'd1, 3'd6, 1'b0);
            else        drive_main(1'b0, 3'd0, 16'd0, 3'd6, 3'd1, 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front(); void'(qbusy.pop_front());
            n_cmp++;
            if (bm.data_out_a !== ea || bm.data_out_b !== eb) begin
                n_err++;
                $display("FAIL dual_read[%0d]: got %h/%h exp %h/%h", i,
                         bm.data_out_a, bm.data_out_b, ea, eb);
            end
        end
    endtask

    task automatic test_no_bypass();
        logic [15:0] e;
        bn.write = 1'b1; bn.writenum = 3'd2; bn.data_in = 16'h0055; bn.readnum_a = 3'd0;
        @(posedge clk); #1;
        bn.data_in = 16'h00AA; bn.readnum_a = 3'd2;
        qn.push_back(16'h0055);
        @(posedge clk); #1;
        bn.write = 1'b0;
        e = qn.pop_front();
        n_cmp++;
        if (bn.data_out_a !== e) begin
            n_err++;
            $display("FAIL nobypass_old: got %h exp %h", bn.data_out_a, e);
        end
        qn.push_back(16'h00AA);
        @(posedge clk); #1;
        e = qn.pop_front();
        n_cmp++;
        if (bn.data_out_a !== e) begin
            n_err++;
            $display("FAIL nobypass_new: got %h exp %h", bn.data_out_a, e);
        end
    endtask

    task automatic test_clear_sweep();
        logic [15:0] ea;
        logic        eb;
        int          highs;
        for (int i = 0; i < 8; i++) drive_main(1'b1, 3'(i), 16'hFFFF, 3'd0, 3'd0, 1'b0);
        qa.delete(); qb.delete(); qbusy.delete();
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            drive_main(i == 3, 3'd5, 16'h1234, (i >= 1 && i <= 8) ? 3'(i - 1) : 3'd0, 3'd5,
                       i == 0 || i == 2);
            ea = qa.pop_front(); void'(qb.pop_front()); eb = qbusy.pop_front();
            if (bm.busy) highs++;
            n_cmp++;
            if (bm.busy !== eb || bm.data_out_a !== ea) begin
                n_err++;
                $display("FAIL sweep[%0d]: got busy=%b a=%h exp busy=%b a=%h", i,
                         bm.busy, bm.data_out_a, eb, ea);
            end
        end
        n_cmp++;
        if (highs != 8) begin
            n_err++;
            $display("FAIL sweep_busy_len: got %0d exp 8", highs);
        end
        for (int i = 0; i < 8; i++) begin
            drive_main(1'b0, 3'd0, 16'd0, 3'(i), 3'(7 - i), 1'b0);
            void'(qa.pop_front()); void'(qb.pop_front()); void'(qbusy.pop_front());
            n_cmp++;
            if (bm.data_out_a !== 16'h0 || bm.data_out_b !== 16'h0) begin
                n_err++;
                $display("FAIL after_clear[%0d]: got %h/%h exp 0/0", i,
                         bm.data_out_a, bm.data_out_b);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic eb;
        for (int i = 0; i < 8; i++) drive_main(1'b1, 3'(i), 16'hA5A5, 3'd0, 3'd0, 1'b0);
        drive_main(1'b0, 3'd0, 16'd0, 3'd6, 3'd7, 1'b1);
        for (int i = 0; i < 3; i++) drive_main(1'b0, 3'd0, 16'd0, 3'd6, 3'd7, 1'b0);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (bm.busy !== 1'b0 || bm.data_out_a !== 16'h0 || bm.data_out_b !== 16'h0) begin
            n_err++;
            $display("FAIL reset_abort: got busy=%b a=%h b=%h exp 0/0/0",
                     bm.busy, bm.data_out_a, bm.data_out_b);
        end
        model_reset();
        #1 reset = 1'b0;
        drive_main(1'b0, 3'd0, 16'd0, 3'd6, 3'd7, 1'b0);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qbusy.pop_front());
        n_cmp++;
        if (bm.data_out_a !== 16'h0 || bm.data_out_b !== 16'h0) begin
            n_err++;
            $display("FAIL reset_regs_zero: got %h/%h exp 0/0", bm.data_out_a, bm.data_out_b);
        end
        for (int i = 0; i < 10; i++) begin
            drive_main(1'b0, 3'd0, 16'd0, 3'd0, 3'd0, i == 0);
            void'(qa.pop_front()); void'(qb.pop_front()); eb = qbusy.pop_front();
            n_cmp++;
            if (bm.busy !== eb) begin
                n_err++;
                $display("FAIL reclear[%0d]: got busy=%b exp %b", i, bm.busy, eb);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea;
        logic [15:0] eb;
        for (int i = 0; i < 40; i++) begin
            drive_main(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
            ea = qa.pop_front(); eb = qb.pop_front(); void'(qbusy.pop_front());
            n_cmp++;
            if (bm.data_out_a !== ea || bm.data_out_b !== eb) begin
                n_err++;
                $display("FAIL b2b[%0d]: got %h/%h exp %h/%h", i,
                         bm.data_out_a, bm.data_out_b, ea, eb);
            end
        end
    endtask

    task automatic test_small_depth();
        logic [31:0] ea;
        logic [31:0] eb;
        int          highs;
        for (int i = 0; i < 5; i++) begin
            bs.write = 1'b1; bs.writenum = 3'(i); bs.data_in = 32'hA000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        // Out-of-range writes, with read A aimed at the same address: no forwarding.
        for (int i = 5; i < 8; i++) begin
            bs.write = 1'b1; bs.writenum = 3'(i); bs.data_in = 32'hDEAD_BEEF;
            bs.readnum_a = 3'(i); bs.readnum_b = 3'd7;
            qs_a.push_back(32'h0); qs_b.push_back(32'h0);
            @(posedge clk); #1;
            ea = qs_a.pop_front(); eb = qs_b.pop_front();
            n_cmp++;
            if (bs.data_out_a !== ea || bs.data_out_b !== eb) begin
                n_err++;
                $display("FAIL small_oor_write[%0d]: got %h/%h exp %h/%h", i,
                         bs.data_out_a, bs.data_out_b, ea, eb);
            end
        end
        bs.write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bs.readnum_a = 3'(i); bs.readnum_b = 3'd7;
            qs_a.push_back(32'hA000_0000 + 32'(i)); qs_b.push_back(32'h0);
            @(posedge clk); #1;
            ea = qs_a.pop_front(); eb = qs_b.pop_front();
            n_cmp++;
            if (bs.data_out_a !== ea || bs.data_out_b !== eb) begin
                n_err++;
                $display("FAIL small_read[%0d]: got %h/%h exp %h/%h", i,
                         bs.data_out_a, bs.data_out_b, ea, eb);
            end
        end
        bs.clear = 1'b1;
        @(posedge clk); #1;
        bs.clear = 1'b0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            if (bs.busy) highs++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (highs != 5) begin
            n_err++;
            $display("FAIL small_busy_len: got %0d exp 5", highs);
        end
        bs.readnum_a = 3'd4;
        @(posedge clk); #1;
        n_cmp++;
        if (bs.data_out_a !== 32'h0) begin
            n_err++;
            $display("FAIL small_cleared: got %h exp 0", bs.data_out_a);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_bypass();
        test_dual_read();
        test_no_bypass();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        test_small_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
